// File: rtl/temp_pkg.sv
// Shared types and default constants for the temperature band classifier.
// Samples are signed, scaled in 0.1 degC units.
package temp_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FRIO   = 2'd1,
    CALOR  = 2'd2
  } estado_temp_t;

  localparam int TEMP_BAJO_DEF = 180;
  localparam int TEMP_ALTO_DEF = 259;
  localparam int ANCHO_TEMP    = 11;

endpackage

// File: rtl/clasificador_temp_histeresis_if.sv
// Sample-in / classification-out bundle between the sensor register
// and the monitoring logic.
interface clasificador_temp_histeresis_if
  import temp_pkg::*;
#(
  parameter int ANCHO     = ANCHO_TEMP,
  parameter int ANCHO_CNT = 16
);

  logic                    muestra_valida;
  logic signed [ANCHO-1:0] temp_entrada;
  logic                    limpiar_cnt;
  estado_temp_t            estado;
  logic                    es_bajo;
  logic                    es_alto;
  logic                    evento;
  logic [ANCHO_CNT-1:0]    cnt_frio;
  logic [ANCHO_CNT-1:0]    cnt_calor;

  modport master (
    output muestra_valida,
    output temp_entrada,
    output limpiar_cnt,
    input  estado,
    input  es_bajo,
    input  es_alto,
    input  evento,
    input  cnt_frio,
    input  cnt_calor
  );

  modport slave (
    input  muestra_valida,
    input  temp_entrada,
    input  limpiar_cnt,
    output estado,
    output es_bajo,
    output es_alto,
    output evento,
    output cnt_frio,
    output cnt_calor
  );

endinterface

// File: rtl/clasificador_temp_histeresis_contador_saturado.sv
// Saturating up-counter with synchronous clear; a clear in the same
// cycle as an increment leaves the count at 1.
module contador_saturado #(
  parameter int ANCHO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [ANCHO-1:0] cuenta
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta <= '0;
    end else if (clr) begin
      cuenta <= ANCHO'(inc);
    end else if (inc && (cuenta != '1)) begin
      cuenta <= cuenta + ANCHO'(1);
    end
  end

endmodule

// File: rtl/clasificador_temp_histeresis.sv
// Hysteretic NORMAL/FRIO/CALOR classifier with N-sample confirmation
// on entry and exit, plus saturating episode counters.
module clasificador_temp_histeresis
  import temp_pkg::*;
#(
  parameter int ANCHO     = ANCHO_TEMP,
  parameter int TEMP_BAJO = TEMP_BAJO_DEF,
  parameter int TEMP_ALTO = TEMP_ALTO_DEF,
  parameter int HIST      = 5,
  parameter int N_CONFIRM = 4,
  parameter int ANCHO_CNT = 16
) (
  input logic clk,
  input logic rst,
  clasificador_temp_histeresis_if.slave bus
);

  localparam int RW = $clog2(N_CONFIRM + 1);

  localparam logic [RW-1:0] N_ULT = RW'(N_CONFIRM - 1);

  localparam logic signed [ANCHO-1:0] UMB_BAJO  = ANCHO'(TEMP_BAJO);
  localparam logic signed [ANCHO-1:0] UMB_ALTO  = ANCHO'(TEMP_ALTO);
  localparam logic signed [ANCHO-1:0] SAL_FRIO  = ANCHO'(TEMP_BAJO + HIST);
  localparam logic signed [ANCHO-1:0] SAL_CALOR = ANCHO'(TEMP_ALTO - HIST);

  if (N_CONFIRM < 1) begin : g_chk_n
    $fatal(1, "N_CONFIRM must be at least 1");
  end
  if (HIST < 0) begin : g_chk_hist
    $fatal(1, "HIST must not be negative");
  end
  if (TEMP_BAJO + HIST > TEMP_ALTO - HIST) begin : g_chk_umb
    $fatal(1, "hysteresis bands overlap");
  end

  estado_temp_t  estado_q;
  logic [RW-1:0] racha_frio;
  logic [RW-1:0] racha_calor;
  logic [RW-1:0] racha_salida;
  logic          es_bajo_q;
  logic          es_alto_q;
  logic          evento_q;

  logic frio_cand;
  logic calor_cand;
  logic salida_ok;
  logic entra_frio;
  logic entra_calor;
  logic sale;

  always_comb begin
    frio_cand  = bus.temp_entrada < UMB_BAJO;
    calor_cand = bus.temp_entrada > UMB_ALTO;
    salida_ok  = 1'b0;
    if (estado_q == FRIO) begin
      salida_ok = bus.temp_entrada >= SAL_FRIO;
    end else if (estado_q == CALOR) begin
      salida_ok = bus.temp_entrada <= SAL_CALOR;
    end
    entra_frio  = bus.muestra_valida && (estado_q == NORMAL)
                  && frio_cand && (racha_frio == N_ULT);
    entra_calor = bus.muestra_valida && (estado_q == NORMAL)
                  && calor_cand && (racha_calor == N_ULT);
    sale        = bus.muestra_valida && salida_ok
                  && (racha_salida == N_ULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q     <= NORMAL;
      racha_frio   <= '0;
      racha_calor  <= '0;
      racha_salida <= '0;
      es_bajo_q    <= 1'b0;
      es_alto_q    <= 1'b0;
      evento_q     <= 1'b0;
    end else begin
      evento_q <= 1'b0;
      if (bus.muestra_valida) begin
        unique case (estado_q)
          NORMAL: begin
            racha_frio  <= frio_cand ? racha_frio + RW'(1) : '0;
            racha_calor <= calor_cand ? racha_calor + RW'(1) : '0;
            if (entra_frio) begin
              estado_q    <= FRIO;
              es_bajo_q   <= 1'b1;
              evento_q    <= 1'b1;
              racha_frio  <= '0;
              racha_calor <= '0;
            end else if (entra_calor) begin
              estado_q    <= CALOR;
              es_alto_q   <= 1'b1;
              evento_q    <= 1'b1;
              racha_frio  <= '0;
              racha_calor <= '0;
            end
          end
          FRIO, CALOR: begin
            racha_salida <= salida_ok ? racha_salida + RW'(1) : '0;
            // Exit always lands in NORMAL; the opposite band must
            // then build its own streak from scratch.
            if (sale) begin
              estado_q     <= NORMAL;
              es_bajo_q    <= 1'b0;
              es_alto_q    <= 1'b0;
              evento_q     <= 1'b1;
              racha_salida <= '0;
            end
          end
          default: begin
            estado_q     <= NORMAL;
            es_bajo_q    <= 1'b0;
            es_alto_q    <= 1'b0;
            racha_frio   <= '0;
            racha_calor  <= '0;
            racha_salida <= '0;
          end
        endcase
      end
    end
  end

  contador_saturado #(
    .ANCHO (ANCHO_CNT)
  ) u_cnt_frio (
    .clk    (clk),
    .rst    (rst),
    .inc    (entra_frio),
    .clr    (bus.limpiar_cnt),
    .cuenta (bus.cnt_frio)
  );

  contador_saturado #(
    .ANCHO (ANCHO_CNT)
  ) u_cnt_calor (
    .clk    (clk),
    .rst    (rst),
    .inc    (entra_calor),
    .clr    (bus.limpiar_cnt),
    .cuenta (bus.cnt_calor)
  );

  assign bus.estado  = estado_q;
  assign bus.es_bajo = es_bajo_q;
  assign bus.es_alto = es_alto_q;
  assign bus.evento  = evento_q;

endmodule
